serial_full_subtractor: RTL and testbench

Bit-serial subtractor: computes `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse-direction companion to the full-adder cells in the arithmetic set, trading area for latency. A start/busy/done handshake frames each operation, and the result is presented in parallel.

---
 rtl/serial_full_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_full_subtractor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock (LSB first) through a
// single full-subtractor cell with a registered borrow; parallel result at the end.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             busy_s;
  logic             last_s;
  logic             d_s;
  logic             br_n_s;

  assign last_s = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave RUN on the edge that processes the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = IDLE;
        else        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      IDLE:    busy_s = 1'b0;
      RUN:     busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d_s    = sa_q[0] ^ sb_q[0] ^ br_q;
    br_n_s = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  end

  // Datapath next values; results only move on the completion edge.
  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    wd_d   = wd_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d  = a;
          sb_d  = b;
          br_d  = bin;
          cnt_d = {CW{1'b0}};
          wd_d  = {WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        wd_d  = {d_s, wd_q[WIDTH-1:1]};
        br_d  = br_n_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (last_s) begin
          diff_d = {d_s, wd_q[WIDTH-1:1]};
          bout_d = br_n_s;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= {WIDTH{1'b0}};
      sb_q   <= {WIDTH{1'b0}};
      wd_q   <= {WIDTH{1'b0}};
      diff_q <= {WIDTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      wd_q   <= wd_d;
      diff_q <= diff_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      bout_q <= bout_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_s;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed self-checking bench: WIDTH=8 instance for handshake/arithmetic cases,
// WIDTH=3 instance for the exhaustive sweep.
module tb_serial_full_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  logic       start3;
  logic [2:0] a3;
  logic [2:0] b3;
  logic       bin3;
  logic       busy3;
  logic       done3;
  logic [2:0] diff3;
  logic       bout3;

  int n_pass;
  int n_total;

  serial_full_subtractor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_full_subtractor #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Returns the number of edges until done is seen, or -1 if the bound expires.
  task automatic wait_done8(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ibin, input logic [7:0] exp_d, input logic exp_b);
    int lat;
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done8(lat);
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_d});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_b});
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {24'd0, diff}, {24'd0, exp_d});
  endtask

  initial begin
    int lat;
    int lat2;
    int ndone;
    logic [7:0] seen_diff;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0; bin = 1'b0;
    start3 = 1'b0; a3 = 3'd0; b3 = 3'd0; bin3 = 1'b0;
    ndone = 0; seen_diff = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8("basic", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0);
    run8("uf_5_9", 8'd5, 8'd9, 1'b0, 8'd252, 1'b1);
    run8("uf_0_0_1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
    run8("uf_255_255_1", 8'd255, 8'd255, 1'b1, 8'd255, 1'b1);

    // start pulsed mid-operation must be ignored
    start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        start = 1'b1; a = 8'd1; b = 8'd2; bin = 1'b1;
      end else if (k == 4) begin
        start = 1'b0;
      end else begin
        start = start;
      end
      if (done) begin
        ndone++;
        seen_diff = diff;
      end
    end
    check("ign_done_count", ndone, 32'd1);
    check("ign_diff", {24'd0, seen_diff}, 32'd30);
    check("ign_bout", {31'd0, bout}, 32'd0);

    // back-to-back: start held in the done cycle
    start = 1'b1; a = 8'd10; b = 8'd3; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done8(lat);
    check("b2b_lat1", lat, 32'd8);
    check("b2b_diff1", {24'd0, diff}, 32'd7);
    start = 1'b1; a = 8'd7; b = 8'd10; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    check("b2b_hold1", {24'd0, diff}, 32'd7);
    wait_done8(lat2);
    check("b2b_spacing", lat2 + 1, 32'd9);
    check("b2b_diff2", {24'd0, diff}, 32'd252);
    check("b2b_bout2", {31'd0, bout}, 32'd1);

    // abort: asynchronous reset mid-cycle at cycle 4 of 8
    start = 1'b1; a = 8'd77; b = 8'd11; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run8("post_abort", 8'd100, 8'd1, 1'b0, 8'd99, 1'b0);

    // exhaustive sweep on the WIDTH=3 instance
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int e;
          int got;
          e = (ia - ib - ic) & 15;
          got = -1;
          start3 = 1'b1; a3 = 3'(ia); b3 = 3'(ib); bin3 = 1'(ic);
          @(posedge clk); #1;
          start3 = 1'b0; a3 = ~a3; b3 = ~b3;
          for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done3) begin
              got = {28'd0, bout3, diff3};
              break;
            end
          end
          check($sformatf("exh_%0d_%0d_%0d", ia, ib, ic), got, e);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
